// File: rtl/jk_bank_driver_if.sv
// Target-word handshake between control logic and jk_bank_driver.
// master: control side offering a target word; slave: the driver accepting it.
interface jk_bank_driver_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_target;

  modport master (output in_valid, output in_target, input in_ready);
  modport slave  (input in_valid, input in_target, output in_ready);
endinterface

// File: rtl/jk_bank_driver.sv
// Drives a bank of external JK flip-flops to a target word, verifies q, and retries.
// Optional macro JK_BANK_DRIVER_TOGGLE_EN: changed bits use j1k1 instead of set/reset.
module jk_bank_driver #(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  jk_bank_driver_if.slave  in_bus,
  input  logic [WIDTH-1:0] q_fb,
  output logic             ff_en,
  output logic [WIDTH-1:0] ff_j,
  output logic [WIDTH-1:0] ff_k,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_mask
);

  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, SAMPLE, DRIVE, CHECK} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] target_reg, target_next;
  logic [3:0]       retry_reg, retry_next;
  logic             ready_reg, ready_next;
  logic             busy_reg, busy_next;
  logic             en_reg, en_next;
  logic [WIDTH-1:0] j_reg, j_next;
  logic [WIDTH-1:0] k_reg, k_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;
  logic [WIDTH-1:0] mask_reg, mask_next;
  logic [WIDTH-1:0] exc_j, exc_k;

  // Excitation is taken from q_fb at the SAMPLE edge; the registered j/k then
  // serve as the snapshot for the DRIVE cycle.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_exc
`ifdef JK_BANK_DRIVER_TOGGLE_EN
      assign exc_j[gi] = q_fb[gi] ^ target_reg[gi];
      assign exc_k[gi] = q_fb[gi] ^ target_reg[gi];
`else
      assign exc_j[gi] = ~q_fb[gi] &  target_reg[gi];
      assign exc_k[gi] =  q_fb[gi] & ~target_reg[gi];
`endif
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      target_reg <= '0;
      retry_reg  <= '0;
      ready_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      en_reg     <= 1'b0;
      j_reg      <= '0;
      k_reg      <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      mask_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      target_reg <= target_next;
      retry_reg  <= retry_next;
      ready_reg  <= ready_next;
      busy_reg   <= busy_next;
      en_reg     <= en_next;
      j_reg      <= j_next;
      k_reg      <= k_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      mask_reg   <= mask_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    target_next = target_reg;
    retry_next  = retry_reg;
    ready_next  = ready_reg;
    busy_next   = busy_reg;
    en_next     = 1'b0;
    j_next      = '0;
    k_next      = '0;
    done_next   = 1'b0;
    err_next    = 1'b0;
    mask_next   = mask_reg;
    case (state_reg)
      IDLE: begin
        ready_next = 1'b1;
        if (in_bus.in_valid && ready_reg) begin
          target_next = in_bus.in_target;
          retry_next  = '0;
          ready_next  = 1'b0;
          busy_next   = 1'b1;
          mask_next   = '0;
          state_next  = SAMPLE;
        end
      end
      SAMPLE: begin
        en_next    = 1'b1;
        j_next     = exc_j;
        k_next     = exc_k;
        state_next = DRIVE;
      end
      DRIVE: begin
        state_next = CHECK;
      end
      CHECK: begin
        if (q_fb == target_reg) begin
          done_next  = 1'b1;
          ready_next = 1'b1;
          busy_next  = 1'b0;
          mask_next  = '0;
          state_next = IDLE;
        end else if (retry_reg < RETRY_LIMIT) begin
          retry_next = retry_reg + 4'd1;
          state_next = SAMPLE;
        end else begin
          err_next   = 1'b1;
          ready_next = 1'b1;
          busy_next  = 1'b0;
          mask_next  = q_fb ^ target_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_bus.in_ready = ready_reg;
  assign ff_en           = en_reg;
  assign ff_j            = j_reg;
  assign ff_k            = k_reg;
  assign busy            = busy_reg;
  assign done            = done_reg;
  assign err             = err_reg;
  assign err_mask        = mask_reg;

endmodule
